// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, stall, flush and an optional skid entry.
// Bubbles never carry live control bits: ctrl/alu_op are gated by out_valid.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_pc_4,
  input  logic [DATA_W-1:0]     in_reg1,
  input  logic [DATA_W-1:0]     in_reg2,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [6:0]            in_ctrl,
  input  logic [ALUOP_W-1:0]    in_alu_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pc_4,
  output logic [DATA_W-1:0]     out_reg1,
  output logic [DATA_W-1:0]     out_reg2,
  output logic [DATA_W-1:0]     out_imm,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [6:0]            out_ctrl,
  output logic [ALUOP_W-1:0]    out_alu_op
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc_4;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            ctrl;
    logic [ALUOP_W-1:0]    alu_op;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKIDF} state_t;

  entry_t in_entry;
  entry_t m_p1;
  entry_t s_p1;
  state_t state_p1;
  state_t state_nxt;
  logic   vld_p1;
  logic   accept;
  logic   drain;
  logic   load_m;
  logic   load_s;
  logic   m_from_s;

  assign in_entry = '{pc_4: in_pc_4, reg1: in_reg1, reg2: in_reg2, imm: in_imm,
                      rt: in_rt, rd: in_rd, ctrl: in_ctrl, alu_op: in_alu_op};

  assign accept = in_valid & in_ready;
  assign drain  = vld_p1 & out_ready;

  always_comb begin
    state_nxt = state_p1;
    load_m    = 1'b0;
    load_s    = 1'b0;
    m_from_s  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            load_m    = 1'b1;
            state_nxt = FULL;
          end
        end
        FULL: begin
          if (accept && drain) begin
            load_m = 1'b1;
          end else if (accept && (SKID != 0)) begin
            load_s    = 1'b1;
            state_nxt = SKIDF;
          end else if (drain) begin
            state_nxt = EMPTY;
          end
        end
        SKIDF: begin
          if (drain) begin
            load_m    = 1'b1;
            m_from_s  = 1'b1;
            state_nxt = FULL;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // ---- stage p1: main and skid entries ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      m_p1     <= '0;
      s_p1     <= '0;
    end else begin
      state_p1 <= state_nxt;
      vld_p1   <= (state_nxt != EMPTY);
      if (load_m) m_p1 <= m_from_s ? s_p1 : in_entry;
      if (load_s) s_p1 <= in_entry;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_ready
      logic rdy_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= (state_nxt != SKIDF);
      end
      assign in_ready = rdy_q;
    end else begin : g_comb_ready
      assign in_ready = ~vld_p1 | out_ready;
    end
  endgenerate

  assign out_valid  = vld_p1;
  assign out_pc_4   = m_p1.pc_4;
  assign out_reg1   = m_p1.reg1;
  assign out_reg2   = m_p1.reg2;
  assign out_imm    = m_p1.imm;
  assign out_rt     = m_p1.rt;
  assign out_rd     = m_p1.rd;
  assign out_ctrl   = vld_p1 ? m_p1.ctrl : 7'h00;
  assign out_alu_op = vld_p1 ? m_p1.alu_op : '0;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: SKID=1/DATA_W=32 instance plus a SKID=0/DATA_W=64 instance.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // SKID=1, default widths
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc_4, in_reg1, in_reg2, in_imm;
  logic [4:0]  in_rt, in_rd;
  logic [6:0]  in_ctrl;
  logic [2:0]  in_alu_op;
  logic [31:0] out_pc_4, out_reg1, out_reg2, out_imm;
  logic [4:0]  out_rt, out_rd;
  logic [6:0]  out_ctrl;
  logic [2:0]  out_alu_op;

  // SKID=0, DATA_W=64
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_pc_4, b_in_reg1, b_in_reg2, b_in_imm;
  logic [4:0]  b_in_rt, b_in_rd;
  logic [6:0]  b_in_ctrl;
  logic [2:0]  b_in_alu_op;
  logic [63:0] b_out_pc_4, b_out_reg1, b_out_reg2, b_out_imm;
  logic [4:0]  b_out_rt, b_out_rd;
  logic [6:0]  b_out_ctrl;
  logic [2:0]  b_out_alu_op;

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(3), .SKID(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_4(in_pc_4), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
    .in_rt(in_rt), .in_rd(in_rd), .in_ctrl(in_ctrl), .in_alu_op(in_alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_4(out_pc_4), .out_reg1(out_reg1), .out_reg2(out_reg2), .out_imm(out_imm),
    .out_rt(out_rt), .out_rd(out_rd), .out_ctrl(out_ctrl), .out_alu_op(out_alu_op)
  );

  id_ex_pipe_reg #(.DATA_W(64), .REG_ADDR_W(5), .ALUOP_W(3), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc_4(b_in_pc_4), .in_reg1(b_in_reg1), .in_reg2(b_in_reg2), .in_imm(b_in_imm),
    .in_rt(b_in_rt), .in_rd(b_in_rd), .in_ctrl(b_in_ctrl), .in_alu_op(b_in_alu_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc_4(b_out_pc_4), .out_reg1(b_out_reg1), .out_reg2(b_out_reg2), .out_imm(b_out_imm),
    .out_rt(b_out_rt), .out_rd(b_out_rd), .out_ctrl(b_out_ctrl), .out_alu_op(b_out_alu_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 0; in_valid = 0; out_ready = 0;
    in_pc_4 = 0; in_reg1 = 0; in_reg2 = 0; in_imm = 0; in_rt = 0; in_rd = 0; in_ctrl = 0; in_alu_op = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0;
    b_in_pc_4 = 0; b_in_reg1 = 0; b_in_reg2 = 0; b_in_imm = 0; b_in_rt = 0; b_in_rd = 0;
    b_in_ctrl = 0; b_in_alu_op = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (out_pc_4 !== 32'h0 || out_ctrl !== 7'h0 || out_rd !== 5'h0)
      begin bad++; $display("FAIL rst_outs pc=%h ctrl=%h rd=%h exp=0", out_pc_4, out_ctrl, out_rd); end
    total++; if (b_out_valid !== 1'b0 || b_out_pc_4 !== 64'h0)
      begin bad++; $display("FAIL rst_b_outs v=%b pc=%h exp=0", b_out_valid, b_out_pc_4); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_valid = 1; in_pc_4 = 32'h100; in_imm = 32'hFFFF_FFF0; in_rd = 5'd7; in_ctrl = 7'h0B; in_alu_op = 3'h2;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_pc_4 !== 32'h100 || out_imm !== 32'hFFFF_FFF0 || out_rd !== 5'd7)
      begin bad++; $display("FAIL mid_load v=%b pc=%h imm=%h rd=%0d exp 1/100/fffffff0/7", out_valid, out_pc_4, out_imm, out_rd); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc_4 !== 32'h0 || out_ctrl !== 7'h0 || out_alu_op !== 3'h0 || out_imm !== 32'h0)
      begin bad++; $display("FAIL mid_reset v=%b pc=%h ctrl=%h op=%h imm=%h exp all 0", out_valid, out_pc_4, out_ctrl, out_alu_op, out_imm); end
    #1 rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("FAIL mid_release rdy=%b v=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1; in_ctrl = 7'h21; in_alu_op = 3'h1;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1; in_pc_4 = 32'(4 * i); in_reg1 = 32'(100 + i);
      tick();
      total++; if (out_valid !== 1'b1 || out_pc_4 !== 32'(4 * i) || out_reg1 !== 32'(100 + i) || in_ready !== 1'b1)
        begin bad++; $display("FAIL stream_%0d v=%b pc=%0d r1=%0d rdy=%b exp 1/%0d/%0d/1", i, out_valid, out_pc_4, out_reg1, in_ready, 4 * i, 100 + i); end
    end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 7'h0)
      begin bad++; $display("FAIL stream_end v=%b ctrl=%h exp 0/0", out_valid, out_ctrl); end
  endtask

  task automatic test_stall();
    out_ready = 0;
    in_valid = 1; in_pc_4 = 32'hA0; in_ctrl = 7'h01; in_alu_op = 3'h3;
    tick();
    total++; if (out_pc_4 !== 32'hA0 || in_ready !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL stall_a pc=%h rdy=%b v=%b exp a0/1/1", out_pc_4, in_ready, out_valid); end
    in_pc_4 = 32'hB0; in_ctrl = 7'h02; in_alu_op = 3'h4;
    tick();
    total++; if (in_ready !== 1'b0 || out_pc_4 !== 32'hA0 || out_ctrl !== 7'h01 || out_alu_op !== 3'h3)
      begin bad++; $display("FAIL stall_b rdy=%b pc=%h ctrl=%h op=%h exp 0/a0/01/3", in_ready, out_pc_4, out_ctrl, out_alu_op); end
    in_pc_4 = 32'hC0; in_ctrl = 7'h04;
    tick();
    total++; if (in_ready !== 1'b0 || out_pc_4 !== 32'hA0 || out_ctrl !== 7'h01)
      begin bad++; $display("FAIL stall_hold rdy=%b pc=%h ctrl=%h exp 0/a0/01", in_ready, out_pc_4, out_ctrl); end
    in_valid = 0; out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc_4 !== 32'hB0 || out_ctrl !== 7'h02 || out_alu_op !== 3'h4 || in_ready !== 1'b1)
      begin bad++; $display("FAIL stall_drain_b v=%b pc=%h ctrl=%h op=%h rdy=%b exp 1/b0/02/4/1", out_valid, out_pc_4, out_ctrl, out_alu_op, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 7'h0)
      begin bad++; $display("FAIL stall_empty v=%b ctrl=%h exp 0/0", out_valid, out_ctrl); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    in_valid = 1; in_pc_4 = 32'h200; in_ctrl = 7'h0B; in_alu_op = 3'h5;
    tick();
    total++; if (out_valid !== 1'b1 || out_ctrl !== 7'h0B || out_alu_op !== 3'h5)
      begin bad++; $display("FAIL flush_load v=%b ctrl=%h op=%h exp 1/0b/5", out_valid, out_ctrl, out_alu_op); end
    flush = 1; in_pc_4 = 32'h300; in_ctrl = 7'h7F; in_alu_op = 3'h7;
    tick();
    flush = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 7'h0 || out_alu_op !== 3'h0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_kill v=%b ctrl=%h op=%h rdy=%b exp 0/0/0/1", out_valid, out_ctrl, out_alu_op, in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 7'h0)
      begin bad++; $display("FAIL flush_drop v=%b ctrl=%h exp 0/0", out_valid, out_ctrl); end
  endtask

  task automatic test_bubble();
    out_ready = 1; in_valid = 0; in_ctrl = 7'h7F; in_alu_op = 3'h7;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || out_ctrl !== 7'h0 || out_alu_op !== 3'h0)
        begin bad++; $display("FAIL bubble_%0d v=%b ctrl=%h op=%h exp 0/0/0", i, out_valid, out_ctrl, out_alu_op); end
    end
  endtask

  task automatic test_skid0();
    b_out_ready = 0;
    b_in_valid = 1; b_in_pc_4 = 64'hFFFF_0000_0000_0004; b_in_ctrl = 7'h09; b_in_alu_op = 3'h6;
    #1;
    total++; if (b_in_ready !== 1'b1)
      begin bad++; $display("FAIL s0_empty_rdy got=%b exp=1", b_in_ready); end
    tick();
    total++; if (b_out_valid !== 1'b1 || b_out_pc_4 !== 64'hFFFF_0000_0000_0004 || b_out_ctrl !== 7'h09 || b_in_ready !== 1'b0)
      begin bad++; $display("FAIL s0_load v=%b pc=%h ctrl=%h rdy=%b exp 1/ffff000000000004/09/0", b_out_valid, b_out_pc_4, b_out_ctrl, b_in_ready); end
    b_out_ready = 1;
    #1;
    total++; if (b_in_ready !== 1'b1)
      begin bad++; $display("FAIL s0_comb_rdy_hi got=%b exp=1", b_in_ready); end
    b_out_ready = 0;
    #1;
    total++; if (b_in_ready !== 1'b0)
      begin bad++; $display("FAIL s0_comb_rdy_lo got=%b exp=0", b_in_ready); end
    b_in_pc_4 = 64'hFFFF_0000_0000_0008;
    tick();
    total++; if (b_out_pc_4 !== 64'hFFFF_0000_0000_0004 || b_out_valid !== 1'b1)
      begin bad++; $display("FAIL s0_stall pc=%h v=%b exp ffff000000000004/1", b_out_pc_4, b_out_valid); end
    b_out_ready = 1;
    tick();
    total++; if (b_out_pc_4 !== 64'hFFFF_0000_0000_0008 || b_out_valid !== 1'b1)
      begin bad++; $display("FAIL s0_reload pc=%h v=%b exp ffff000000000008/1", b_out_pc_4, b_out_valid); end
    b_in_valid = 0;
    tick();
    total++; if (b_out_valid !== 1'b0 || b_out_ctrl !== 7'h0 || b_out_alu_op !== 3'h0)
      begin bad++; $display("FAIL s0_drain v=%b ctrl=%h op=%h exp 0/0/0", b_out_valid, b_out_ctrl, b_out_alu_op); end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_skid0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
